// File: rtl/control_unit.sv
// control_unit: Moore sequencer for a simple load/store datapath.
// Walks fetch, an optional data-memory access and up to five execute steps
// per instruction, decoding the instruction class from ir[31:27].
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH0 | PC onto bus, load MAR, Z <= PC + 1
// FETCH1 | PC <= Z, arm fetch flag
// MEM_RD | memory read in progress; waits for mem_ready
// FETCH2 | IR <= MDR, clear fetch flag
// EX3    | first execute step (ir decoded from here on)
// EX4    | second execute step
// EX5    | third execute step
// EX6    | fourth execute step (mul/div high half, st data, branch)
// EX7    | ld write-back after the data read
// MEM_WR | memory write in progress; waits for mem_ready
// HALT   | absorbing stop; only clear leaves it
module control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        PC_enable,
    output logic        IR_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        Y_enable,
    output logic        Z_low_enable,
    output logic        Z_high_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        LinkIn,
    output logic        CON_enable,
    output logic        OutPort_enable,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Run,
    output logic [4:0]  operation
);

    typedef enum logic [3:0] {
        FETCH0, FETCH1, MEM_RD, FETCH2, EX3, EX4, EX5, EX6, EX7, MEM_WR, HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
    } op_class_t;

    state_t    state, state_next;
    logic      fetch_flag, fetch_next;
    op_class_t op_class;
    logic [4:0] opcode;

    assign opcode = ir[31:27];

    // Operand/immediate fields belong to the datapath, not to sequencing.
    logic unused_ir_fields;
    assign unused_ir_fields = &{1'b0, ir[26:0]};

    // State register and fetch flag; clear forces a fresh fetch at once.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= FETCH0;
            fetch_flag <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_flag <= fetch_next;
        end
    end

    // Opcode to instruction class; anything unlisted behaves as nop.
    always_comb begin
        op_class = C_NOP;
        if (opcode >= 5'b00011 && opcode <= 5'b01011)
            op_class = C_ALU;
        else if (opcode >= 5'b01100 && opcode <= 5'b01110)
            op_class = C_IMM;
        else begin
            case (opcode)
                5'b00000: op_class = C_LD;
                5'b00001: op_class = C_LDI;
                5'b00010: op_class = C_ST;
                5'b01111,
                5'b10000: op_class = C_MULDIV;
                5'b10001,
                5'b10010: op_class = C_NEGNOT;
                5'b10011: op_class = C_BR;
                5'b10100: op_class = C_JR;
                5'b10101: op_class = C_JAL;
                5'b10110: op_class = C_IN;
                5'b10111: op_class = C_OUT;
                5'b11000: op_class = C_MFHI;
                5'b11001: op_class = C_MFLO;
                5'b11011: op_class = C_HALT;
                default:  op_class = C_NOP;
            endcase
        end
    end

    // Next state and Moore outputs; everything is forced low while clear is
    // asserted so an in-flight Read/Write drops without waiting for a clock.
    always_comb begin
        state_next     = state;
        fetch_next     = fetch_flag;
        PCout          = 1'b0;
        ZLowout        = 1'b0;
        ZHighout       = 1'b0;
        MDRout         = 1'b0;
        HIout          = 1'b0;
        LOout          = 1'b0;
        Cout           = 1'b0;
        InPortout      = 1'b0;
        PC_enable      = 1'b0;
        IR_enable      = 1'b0;
        MAR_enable     = 1'b0;
        MDR_enable     = 1'b0;
        Y_enable       = 1'b0;
        Z_low_enable   = 1'b0;
        Z_high_enable  = 1'b0;
        HI_enable      = 1'b0;
        LO_enable      = 1'b0;
        Gra            = 1'b0;
        Grb            = 1'b0;
        Grc            = 1'b0;
        Rin            = 1'b0;
        Rout           = 1'b0;
        BAout          = 1'b0;
        LinkIn         = 1'b0;
        CON_enable     = 1'b0;
        OutPort_enable = 1'b0;
        IncPC          = 1'b0;
        Read           = 1'b0;
        Write          = 1'b0;
        Run            = 1'b0;
        operation      = 5'b00000;

        if (clear) begin
            Run = (state != HALT);
            case (state)
                FETCH0: begin
                    PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; Z_low_enable = 1'b1;
                    state_next = FETCH1;
                end
                FETCH1: begin
                    ZLowout = 1'b1; PC_enable = 1'b1;
                    fetch_next = 1'b1;
                    state_next = MEM_RD;
                end
                MEM_RD: begin
                    Read = 1'b1;
                    MDR_enable = mem_ready;
                    if (mem_ready)
                        state_next = fetch_flag ? FETCH2 : EX7;
                end
                FETCH2: begin
                    MDRout = 1'b1; IR_enable = 1'b1;
                    fetch_next = 1'b0;
                    state_next = EX3;
                end
                EX3: begin
                    state_next = FETCH0;
                    case (op_class)
                        C_ALU, C_IMM: begin
                            Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1; state_next = EX4;
                        end
                        C_NEGNOT: begin
                            Grb = 1'b1; Rout = 1'b1; operation = opcode; Z_low_enable = 1'b1;
                            state_next = EX4;
                        end
                        C_MULDIV: begin
                            Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1; state_next = EX4;
                        end
                        C_LD, C_LDI, C_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; state_next = EX4;
                        end
                        C_BR: begin
                            Gra = 1'b1; Rout = 1'b1; CON_enable = 1'b1; state_next = EX4;
                        end
                        C_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
                        C_JAL:  begin PCout = 1'b1; LinkIn = 1'b1; state_next = EX4; end
                        C_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; end
                        C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_HALT: state_next = HALT;
                        default: state_next = FETCH0;
                    endcase
                end
                EX4: begin
                    state_next = FETCH0;
                    case (op_class)
                        C_ALU: begin
                            Grc = 1'b1; Rout = 1'b1; operation = opcode; Z_low_enable = 1'b1;
                            state_next = EX5;
                        end
                        C_IMM: begin
                            Cout = 1'b1; operation = opcode; Z_low_enable = 1'b1;
                            state_next = EX5;
                        end
                        C_NEGNOT: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; operation = opcode;
                            Z_low_enable = 1'b1; Z_high_enable = 1'b1;
                            state_next = EX5;
                        end
                        C_LD, C_LDI, C_ST: begin
                            Cout = 1'b1; operation = ADD_OP; Z_low_enable = 1'b1;
                            state_next = EX5;
                        end
                        C_BR:  begin PCout = 1'b1; Y_enable = 1'b1; state_next = EX5; end
                        C_JAL: begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
                        default: state_next = FETCH0;
                    endcase
                end
                EX5: begin
                    state_next = FETCH0;
                    case (op_class)
                        C_ALU, C_IMM, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_MULDIV: begin ZLowout = 1'b1; LO_enable = 1'b1; state_next = EX6; end
                        // Data read reuses MEM_RD; the cleared fetch flag routes it to EX7.
                        C_LD: begin ZLowout = 1'b1; MAR_enable = 1'b1; state_next = MEM_RD; end
                        C_ST: begin ZLowout = 1'b1; MAR_enable = 1'b1; state_next = EX6; end
                        C_BR: begin
                            Cout = 1'b1; operation = ADD_OP; Z_low_enable = 1'b1;
                            state_next = EX6;
                        end
                        default: state_next = FETCH0;
                    endcase
                end
                EX6: begin
                    state_next = FETCH0;
                    case (op_class)
                        C_MULDIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                        C_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; state_next = MEM_WR;
                        end
                        C_BR: begin
                            ZLowout = con_ff; PC_enable = con_ff;
                        end
                        default: state_next = FETCH0;
                    endcase
                end
                EX7: begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    state_next = FETCH0;
                end
                MEM_WR: begin
                    Write = 1'b1;
                    if (mem_ready)
                        state_next = FETCH0;
                end
                HALT: state_next = HALT;
                default: state_next = FETCH0;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ADD_OP, default 5'b00011, ALU operation code driven for address and offset additions.
REQ-002 clock  input  1  single clock; all state changes occur on its rising edge.
REQ-003 clear  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 ir  input  32  instruction register contents; opcode=ir[31:27].
REQ-005 con_ff  input  1  branch condition flag; sampled in branch step EX6.
REQ-006 mem_ready  input  1  memory completion handshake for read and write.
REQ-007 PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout  output  1 each  bus source selects.
REQ-008 PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_low_enable, Z_high_enable, HI_enable, LO_enable  output  1 each  register loads.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout, LinkIn, CON_enable, OutPort_enable, IncPC, Read, Write, Run  output  1 each  register-file select, misc controls, status.
REQ-010 operation  output  5  ALU opcode.

Function
REQ-011 Moore FSM; outputs decode from current state, except MDR_enable in MEM_RD, which equals mem_ready.
REQ-012 States: FETCH0, FETCH1, MEM_RD, FETCH2, EX3..EX7, MEM_WR, HALT; every state lasts 1 cycle unless stated.
REQ-013 Any output not named for a state is 0; operation=0 unless named.
REQ-014 FETCH0: PCout, MAR_enable, IncPC, Z_low_enable -> FETCH1.
REQ-015 FETCH1: ZLowout, PC_enable -> MEM_RD (fetch flag set).
REQ-016 MEM_RD: Read=1; waits while mem_ready=0; on mem_ready=1 -> FETCH2 if fetch flag set, else EX7.
REQ-017 FETCH2: MDRout, IR_enable -> EX3; fetch flag clears.
REQ-018 R-type ALU (opcodes 00011-01011): EX3 Grb,Rout,Y_enable; EX4 Grc,Rout,operation=opcode,Z_low_enable; EX5 ZLowout,Gra,Rin.
REQ-019 Immediate (01100-01110): EX3 Grb,Rout,Y_enable; EX4 Cout,operation=opcode,Z_low_enable; EX5 ZLowout,Gra,Rin.
REQ-020 neg/not (10001,10010): EX3 Grb,Rout,operation=opcode,Z_low_enable; EX4 ZLowout,Gra,Rin.
REQ-021 div/mul (01111,10000): EX3 Gra,Rout,Y_enable; EX4 Grb,Rout,operation=opcode,Z_low_enable,Z_high_enable; EX5 ZLowout,LO_enable; EX6 ZHighout,HI_enable.
REQ-022 ld/ldi/st (00000,00001,00010): EX3 Grb,BAout,Y_enable; EX4 Cout,operation=ADD_OP,Z_low_enable.
REQ-023 ldi EX5: ZLowout,Gra,Rin. ld EX5: ZLowout,MAR_enable -> MEM_RD; EX7: MDRout,Gra,Rin.
REQ-024 st EX5: ZLowout,MAR_enable; EX6: Gra,Rout,MDR_enable -> MEM_WR; MEM_WR: Write=1, waits until mem_ready=1.
REQ-025 Branch (10011): EX3 Gra,Rout,CON_enable; EX4 PCout,Y_enable; EX5 Cout,operation=ADD_OP,Z_low_enable; EX6 ZLowout and PC_enable only if con_ff=1.
REQ-026 jr (10100): EX3 Gra,Rout,PC_enable. jal (10101): EX3 PCout,LinkIn; EX4 Gra,Rout,PC_enable.
REQ-027 in (10110): EX3 InPortout,Gra,Rin. out (10111): EX3 Gra,Rout,OutPort_enable.
REQ-028 mfhi (11000): EX3 HIout,Gra,Rin. mflo (11001): EX3 LOout,Gra,Rin.
REQ-029 nop (11010) and undefined opcodes: EX3 asserts nothing.
REQ-030 halt (11011): -> HALT; HALT is absorbing, Run=0, all other outputs 0.
REQ-031 After the final step of any instruction -> FETCH0.
REQ-032 ir is used only in states EX3 onward; ir changes in other states have no effect.
REQ-033 Run=1 in every state except HALT.
REQ-034 At most one bus source select is 1 in any cycle.

Reset
REQ-035 clear=0 forces FETCH0 immediately; fetch flag clears.
REQ-036 While clear=0, all outputs are 0, including Run; this holds mid-MEM_RD and mid-MEM_WR (Read/Write drop without waiting for a clock).
REQ-037 On the first rising edge after clear=1, the FSM is in FETCH0 with FETCH0 outputs and Run=1.

Verification
REQ-038 Release reset; mem_ready=1; ir=add (5'b00011) -> FETCH0..FETCH2 then EX3-EX5 outputs per REQ-018, operation=00011 in EX4; back in FETCH0 after 7 cycles.
REQ-039 ld, mem_ready held 0 for 3 cycles in data read -> Read=1 for 4 cycles, MDR_enable=1 only in the last; EX7 follows.
REQ-040 Branch with con_ff=0 -> EX6 has PC_enable=0; repeat with con_ff=1 -> EX6 has ZLowout=1 and PC_enable=1.
REQ-041 mul -> Z_low_enable and Z_high_enable both 1 in EX4; LO_enable in EX5; HI_enable in EX6.
REQ-042 clear pulsed low during MEM_WR -> Write=0 asynchronously; after release, FETCH0 outputs appear.
REQ-043 halt -> Run=0 and outputs frozen at 0 for 20+ cycles; only clear exits.
